write_ptr_full_logic: RTL and testbench

- Write-domain pointer stage of the asynchronous FIFO, directly upstream of the read-pointer stage.
- Accepts write requests and produces the binary write address for the dual-port memory.
- Produces the registered Gray write pointer that the 2-flop synchronizer carries into the read domain.
- Computes full, almost_full, fill level and a sticky overflow flag from the read pointer already synchronized into wclk.

---
 rtl/write_ptr_full_logic_pkg.sv | 23 ++
 rtl/bcd_gray.sv | 14 +
 rtl/gray_bcd.sv | 17 +
 rtl/write_ptr_full_logic.sv | 77 +++++++
 tb/tb_write_ptr_full_logic.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/write_ptr_full_logic_pkg.sv
// rtl/write_ptr_full_logic_pkg.sv - shared async FIFO constants and Gray/binary conversions
package write_ptr_full_logic_pkg;

  localparam int DEPTH_DEF        = 8;
  localparam int ADDR_W_DEF       = 3;
  localparam int PTR_W            = ADDR_W_DEF + 1;
  localparam int AFULL_THRESH_DEF = 6;

  // Binary to reflected Gray at the default pointer width.
  function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Reflected Gray to binary: bit i is the XOR of all Gray bits at or above i.
  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] gray);
    logic [PTR_W-1:0] bin;
    for (int i = 0; i < PTR_W; i++) begin
      bin[i] = ^(gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/bcd_gray.sv
// rtl/bcd_gray.sv - binary to Gray converter
module bcd_gray #(
  parameter int W = 4
) (
  input  logic [W-1:0] bin,
  output logic [W-1:0] gray
);

  // Each Gray bit is the XOR of adjacent binary bits.
  always_comb begin
    gray = bin ^ (bin >> 1);
  end

endmodule

// File: rtl/gray_bcd.sv
// rtl/gray_bcd.sv - Gray to binary converter
module gray_bcd #(
  parameter int W = 4
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // Bit i is the parity of the Gray bits from i upward.
  always_comb begin
    bin = '0;
    for (int i = 0; i < W; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/write_ptr_full_logic.sv
// rtl/write_ptr_full_logic.sv - async FIFO write pointer, full and level logic
module write_ptr_full_logic
  import write_ptr_full_logic_pkg::*;
#(
  parameter int DEPTH        = DEPTH_DEF,
  parameter int ADDR_W       = $clog2(DEPTH),
  parameter int AFULL_THRESH = AFULL_THRESH_DEF
) (
  input  logic              wclk,
  input  logic              reset,
  input  logic              w_en,
  input  logic [ADDR_W:0]   gray_r_ptr_syn,
  output logic [ADDR_W:0]   bin_w_ptr,
  output logic [ADDR_W:0]   gray_w_ptr,
  output logic [ADDR_W:0]   bin_r_ptr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wr_level,
  output logic              overflow,
  input  logic              overflow_clr
);

  localparam int PW = ADDR_W + 1;

  logic [ADDR_W:0] bin_next;
  logic [ADDR_W:0] gray_next;
  logic            accept;

  // Gray of the incremented pointer, registered below so the CDC source is glitch-free.
  bcd_gray #(.W(PW)) u_bcd_gray (
    .bin  (bin_next),
    .gray (gray_next)
  );

  // Synchronized read pointer back to binary for level arithmetic.
  gray_bcd #(.W(PW)) u_gray_bcd (
    .gray (gray_r_ptr_syn),
    .bin  (bin_r_ptr)
  );

  // Level, full/almost_full and accept; reset gates the strobe so no write slips out.
  always_comb begin
    bin_next    = bin_w_ptr + PW'(1);
    wr_level    = bin_w_ptr - bin_r_ptr;
    full        = (bin_w_ptr[ADDR_W] != bin_r_ptr[ADDR_W]) &&
                  (bin_w_ptr[ADDR_W-1:0] == bin_r_ptr[ADDR_W-1:0]);
    almost_full = (wr_level >= PW'(AFULL_THRESH));
    accept      = w_en & ~full & ~reset;
    mem_we      = accept;
    mem_waddr   = bin_w_ptr[ADDR_W-1:0];
  end

  // Advance binary and Gray pointers together on an accepted write.
  always_ff @(posedge wclk or posedge reset) begin
    if (reset) begin
      bin_w_ptr  <= '0;
      gray_w_ptr <= '0;
    end else if (accept) begin
      bin_w_ptr  <= bin_next;
      gray_w_ptr <= gray_next;
    end
  end

  // Sticky overflow: a blocked write sets it and beats a simultaneous clear.
  always_ff @(posedge wclk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (w_en && full) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_write_ptr_full_logic.sv
// tb/tb_write_ptr_full_logic.sv - scoreboard bench for the write pointer stage
module tb_write_ptr_full_logic;

  logic       wclk = 1'b0;
  logic       reset = 1'b1;
  logic       w_en = 1'b1;
  logic [3:0] gray_r_ptr_syn = 4'd0;
  logic       overflow_clr = 1'b0;
  logic [3:0] bin_w_ptr, gray_w_ptr, bin_r_ptr, wr_level;
  logic       mem_we, full, almost_full, overflow;
  logic [2:0] mem_waddr;

  write_ptr_full_logic #(.DEPTH(8), .ADDR_W(3), .AFULL_THRESH(6)) dut (
    .wclk           (wclk),
    .reset          (reset),
    .w_en           (w_en),
    .gray_r_ptr_syn (gray_r_ptr_syn),
    .bin_w_ptr      (bin_w_ptr),
    .gray_w_ptr     (gray_w_ptr),
    .bin_r_ptr      (bin_r_ptr),
    .mem_we         (mem_we),
    .mem_waddr      (mem_waddr),
    .full           (full),
    .almost_full    (almost_full),
    .wr_level       (wr_level),
    .overflow       (overflow),
    .overflow_clr   (overflow_clr)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    logic [3:0] bw, gw, br, lv;
    logic       we, fu, af, ov;
    logic [2:0] wa;
    logic       wrap;
    string      name;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;
  logic [3:0] gtab [16];

  function automatic exp_t mk(string n, logic [3:0] bw, logic [3:0] gw, logic [3:0] br,
                              logic we, logic [2:0] wa, logic fu, logic af,
                              logic [3:0] lv, logic ov, logic wrap);
    exp_t e;
    e.name = n; e.bw = bw; e.gw = gw; e.br = br; e.we = we; e.wa = wa;
    e.fu = fu; e.af = af; e.lv = lv; e.ov = ov; e.wrap = wrap;
    return e;
  endfunction

  task automatic chk(string v, string f, int act, int req);
    if (act != req) begin
      miscompares++;
      $display("FAIL %s.%s: got %0d, expected %0d", v, f, act, req);
    end
  endtask

  // Monitor: every falling edge with a pending expectation is compared.
  initial begin
    exp_t e;
    logic [3:0] last_gray;
    last_gray = 4'd0;
    forever begin
      @(negedge wclk);
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        chk(e.name, "bin_w_ptr",   int'(bin_w_ptr),   int'(e.bw));
        chk(e.name, "gray_w_ptr",  int'(gray_w_ptr),  int'(e.gw));
        chk(e.name, "bin_r_ptr",   int'(bin_r_ptr),   int'(e.br));
        chk(e.name, "mem_we",      int'(mem_we),      int'(e.we));
        chk(e.name, "mem_waddr",   int'(mem_waddr),   int'(e.wa));
        chk(e.name, "full",        int'(full),        int'(e.fu));
        chk(e.name, "almost_full", int'(almost_full), int'(e.af));
        chk(e.name, "wr_level",    int'(wr_level),    int'(e.lv));
        chk(e.name, "overflow",    int'(overflow),    int'(e.ov));
        if (e.wrap)
          chk(e.name, "gray_bits_changed", $countones(gray_w_ptr ^ last_gray), 1);
        last_gray = gray_w_ptr;
      end
    end
  end

  // Drive one cycle just after the rising edge and queue what that cycle must show.
  task automatic step(logic we_v, logic [3:0] gr, logic clr, exp_t e);
    @(posedge wclk);
    #1;
    w_en = we_v; gray_r_ptr_syn = gr; overflow_clr = clr;
    q.push_back(e);
  endtask

  initial begin
    int b;
    gtab[0] = 4'h0;  gtab[1] = 4'h1;  gtab[2] = 4'h3;  gtab[3] = 4'h2;
    gtab[4] = 4'h6;  gtab[5] = 4'h7;  gtab[6] = 4'h5;  gtab[7] = 4'h4;
    gtab[8] = 4'hC;  gtab[9] = 4'hD;  gtab[10] = 4'hF; gtab[11] = 4'hE;
    gtab[12] = 4'hA; gtab[13] = 4'hB; gtab[14] = 4'h9; gtab[15] = 4'h8;

    // Reset held with a write request pending.
    step(1, 4'h0, 0, mk("rst_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge wclk); #1;
    reset = 1'b0;
    q.push_back(mk("rel", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));

    // Eight back-to-back writes fill the FIFO.
    for (int k = 1; k < 8; k++)
      step(1, 4'h0, 0, mk($sformatf("fill%0d", k), 4'(k), gtab[k], 0, 1, 3'(k), 0,
                          (k >= 6), 4'(k), 0, 0));
    step(1, 4'h0, 0, mk("full_blk1", 8, 4'hC, 0, 0, 0, 1, 1, 8, 0, 0));
    step(1, 4'h0, 1, mk("full_blk_clr", 8, 4'hC, 0, 0, 0, 1, 1, 8, 1, 0));
    step(0, 4'h0, 1, mk("clr_alone", 8, 4'hC, 0, 0, 0, 1, 1, 8, 1, 0));
    step(0, 4'h2, 0, mk("rd_adv", 8, 4'hC, 3, 0, 0, 0, 0, 5, 0, 0));
    step(1, 4'h2, 0, mk("wr_after", 8, 4'hC, 3, 1, 0, 0, 0, 5, 0, 0));
    step(0, 4'h2, 0, mk("post_wr", 9, 4'hD, 3, 0, 1, 0, 1, 6, 0, 0));

    // Wrap-around with the read pointer two behind.
    b = 9;
    for (int k = 0; k < 10; k++) begin
      step(1, gtab[(b - 2) & 15], 0,
           mk($sformatf("wrap%0d", k), 4'(b), gtab[b], 4'((b - 2) & 15), 1, 3'(b & 7),
              0, 0, 2, 0, (k > 0)));
      b = (b + 1) & 15;
    end

    // Level 5, then asynchronous reset in the middle of the next cycle.
    step(0, 4'h9, 0, mk("lvl5", 3, 4'h2, 14, 0, 3, 0, 0, 5, 0, 1));
    @(posedge wclk); #1;
    w_en = 1'b1;
    q.push_back(mk("async_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    reset = 1'b1; gray_r_ptr_syn = 4'h0;
    step(1, 4'h0, 0, mk("rst_hold2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge wclk); #1;
    reset = 1'b0;
    q.push_back(mk("rel2", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));

    for (int t = 0; t < 5 && q.size() > 0; t++) @(posedge wclk);
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    @(posedge wclk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
